// File: rtl/ddrphy_csr_tdr_pkg.sv
// Purpose: shared widths, command field offsets, FSM states for the CSR-access TDR bridge.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ddrphy_csr_tdr_pkg;

    localparam int CSR_ADDR_W = 28;
    localparam int CSR_DATA_W = 16;
    localparam int CSR_CMD_W  = CSR_DATA_W + 1 + CSR_ADDR_W;

    // Command chain layout, LSB first on the wire: addr, we, data.
    localparam int CMD_ADDR_LSB = 0;
    localparam int CMD_WE_BIT   = CSR_ADDR_W;
    localparam int CMD_DATA_LSB = CSR_ADDR_W + 1;

    // Read-back value presented when a read is abandoned for lack of an ack.
    localparam logic [15:0] TIMEOUT_RDDATA = 16'hDEAD;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } csr_state_e;

endpackage

// File: rtl/tdr_shift_chain.sv
// Purpose: one TDR shift chain with parallel capture; capture beats shift on the same edge.
// Latency: capture/shift visible one TDRCLK edge later; tdo is the chain LSB straight from the flop.
// Backpressure: none; the TDR master owns the enables.
// Ports: TDRCLK/WRST clock and sync reset; wsi serial in; capture_en/shift_en chain ops;
//        capture_dat parallel load source; sr_dat chain contents; tdo serial out (bit 0).
module tdr_shift_chain #(
    parameter int W = 16
) (
    input  logic         TDRCLK,
    input  logic         WRST,
    input  logic         wsi,
    input  logic         capture_en,
    input  logic         shift_en,
    input  logic [W-1:0] capture_dat,
    output logic [W-1:0] sr_dat,
    output logic         tdo
);

    always_ff @(posedge TDRCLK) begin
        if (WRST) begin
            sr_dat <= '0;
        end else if (capture_en) begin
            sr_dat <= capture_dat;
        end else if (shift_en) begin
            sr_dat <= {wsi, sr_dat[W-1:1]};
        end
    end

    assign tdo = sr_dat[0];

endmodule

// File: rtl/ddrphy_csr_tdr_bridge.sv
// Purpose: turns each command-TDR update into one Cfg-bus CSR access and holds read data for the read-data TDR.
// Latency: CsrReq rises one edge after update, drops one edge after CsrAck or after ACK_TIMEOUT cycles.
// Backpressure: none upstream; an update arriving while an access is in flight is dropped and flagged sticky.
// Ports: TDRCLK/WRST clock and sync reset; WSI shared serial in; DdrPhyCsrCmdTdr* command chain ops and tdo;
//        DdrPhyCsrRdDataTdr* read-data chain ops and tdo; Csr* Cfg-bus request/response; CsrBusy,
//        CsrTimeoutErr, CsrOverrunErr status.
module ddrphy_csr_tdr_bridge
    import ddrphy_csr_tdr_pkg::*;
#(
    parameter int ADDR_W      = CSR_ADDR_W,
    parameter int DATA_W      = CSR_DATA_W,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              TDRCLK,
    input  logic              WRST,
    input  logic              WSI,
    input  logic              DdrPhyCsrCmdTdrCaptureEn,
    input  logic              DdrPhyCsrCmdTdrShiftEn,
    input  logic              DdrPhyCsrCmdTdrUpdateEn,
    output logic              DdrPhyCsrCmdTdr_Tdo,
    input  logic              DdrPhyCsrRdDataTdrCaptureEn,
    input  logic              DdrPhyCsrRdDataTdrShiftEn,
    input  logic              DdrPhyCsrRdDataTdrUpdateEn,
    output logic              DdrPhyCsrRdDataTdr_Tdo,
    output logic              CsrReq,
    output logic              CsrWe,
    output logic [ADDR_W-1:0] CsrAddr,
    output logic [DATA_W-1:0] CsrWrData,
    input  logic              CsrAck,
    input  logic [DATA_W-1:0] CsrRdData,
    output logic              CsrBusy,
    output logic              CsrTimeoutErr,
    output logic              CsrOverrunErr
);

    localparam int CMD_W    = DATA_W + 1 + ADDR_W;
    localparam int WE_BIT   = ADDR_W;
    localparam int DATA_LSB = ADDR_W + 1;
    localparam int CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

    csr_state_e        state_q;
    csr_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CMD_W-1:0]  cmd_sr;
    logic [CMD_W-1:0]  cmd_shadow;
    logic [DATA_W-1:0] rd_hold;
    logic [DATA_W-1:0] unused_rd_sr;
    logic              unused_rd_update;

    logic accept;
    logic ack_done;
    logic to_done;
    logic overrun;

    // Read-data chain update has nothing to commit: reading is non-destructive.
    assign unused_rd_update = DdrPhyCsrRdDataTdrUpdateEn;

    tdr_shift_chain #(.W(CMD_W)) u_cmd_chain (
        .TDRCLK      (TDRCLK),
        .WRST        (WRST),
        .wsi         (WSI),
        .capture_en  (DdrPhyCsrCmdTdrCaptureEn),
        .shift_en    (DdrPhyCsrCmdTdrShiftEn),
        .capture_dat (cmd_shadow),
        .sr_dat      (cmd_sr),
        .tdo         (DdrPhyCsrCmdTdr_Tdo)
    );

    tdr_shift_chain #(.W(DATA_W)) u_rd_chain (
        .TDRCLK      (TDRCLK),
        .WRST        (WRST),
        .wsi         (WSI),
        .capture_en  (DdrPhyCsrRdDataTdrCaptureEn),
        .shift_en    (DdrPhyCsrRdDataTdrShiftEn),
        .capture_dat (rd_hold),
        .sr_dat      (unused_rd_sr),
        .tdo         (DdrPhyCsrRdDataTdr_Tdo)
    );

    always_ff @(posedge TDRCLK) begin
        if (WRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is checked before the timeout so a coincident ack completes normally.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        ack_done = 1'b0;
        to_done  = 1'b0;
        overrun  = 1'b0;
        case (state_q)
            IDLE: begin
                if (DdrPhyCsrCmdTdrUpdateEn) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                overrun = DdrPhyCsrCmdTdrUpdateEn;
                if (CsrAck) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    to_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge TDRCLK) begin
        if (WRST) begin
            cnt_q         <= '0;
            cmd_shadow    <= '0;
            rd_hold       <= '0;
            CsrWe         <= 1'b0;
            CsrAddr       <= '0;
            CsrWrData     <= '0;
            CsrTimeoutErr <= 1'b0;
            CsrOverrunErr <= 1'b0;
        end else begin
            if (accept) begin
                // Pre-edge chain contents; the chain itself is left untouched.
                cmd_shadow <= cmd_sr;
                CsrWe      <= cmd_sr[WE_BIT];
                CsrAddr    <= cmd_sr[ADDR_W-1:0];
                CsrWrData  <= cmd_sr[CMD_W-1:DATA_LSB];
                cnt_q      <= '0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (ack_done && !CsrWe) begin
                rd_hold <= CsrRdData;
            end else if (to_done && !CsrWe) begin
                rd_hold <= DATA_W'(TIMEOUT_RDDATA);
            end

            if (to_done) begin
                CsrTimeoutErr <= 1'b1;
            end
            if (overrun) begin
                CsrOverrunErr <= 1'b1;
            end
        end
    end

    assign CsrReq  = (state_q == REQ);
    assign CsrBusy = (state_q == REQ);

endmodule

// File: tb/tb_ddrphy_csr_tdr_bridge.sv
module tb_ddrphy_csr_tdr_bridge;
    import ddrphy_csr_tdr_pkg::*;

    logic        TDRCLK = 1'b0;
    logic        WRST   = 1'b1;
    logic        WSI    = 1'b0;
    logic        cmd_cap = 1'b0, cmd_shift = 1'b0, cmd_upd = 1'b0;
    logic        rd_cap  = 1'b0, rd_shift  = 1'b0, rd_upd  = 1'b0;
    logic        cmd_tdo, rd_tdo;
    logic        CsrReq, CsrWe, CsrBusy, CsrTimeoutErr, CsrOverrunErr;
    logic [27:0] CsrAddr;
    logic [15:0] CsrWrData;
    logic        CsrAck = 1'b0;
    logic [15:0] CsrRdData = 16'h0;

    ddrphy_csr_tdr_bridge dut (
        .TDRCLK                      (TDRCLK),
        .WRST                        (WRST),
        .WSI                         (WSI),
        .DdrPhyCsrCmdTdrCaptureEn    (cmd_cap),
        .DdrPhyCsrCmdTdrShiftEn      (cmd_shift),
        .DdrPhyCsrCmdTdrUpdateEn     (cmd_upd),
        .DdrPhyCsrCmdTdr_Tdo         (cmd_tdo),
        .DdrPhyCsrRdDataTdrCaptureEn (rd_cap),
        .DdrPhyCsrRdDataTdrShiftEn   (rd_shift),
        .DdrPhyCsrRdDataTdrUpdateEn  (rd_upd),
        .DdrPhyCsrRdDataTdr_Tdo      (rd_tdo),
        .CsrReq                      (CsrReq),
        .CsrWe                       (CsrWe),
        .CsrAddr                     (CsrAddr),
        .CsrWrData                   (CsrWrData),
        .CsrAck                      (CsrAck),
        .CsrRdData                   (CsrRdData),
        .CsrBusy                     (CsrBusy),
        .CsrTimeoutErr               (CsrTimeoutErr),
        .CsrOverrunErr               (CsrOverrunErr)
    );

    always #5 TDRCLK = ~TDRCLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [27:0] addr;
        logic [15:0] data;
        int          len;
    } txn_t;

    txn_t exp_txn[$];
    logic exp_rd[$];
    logic exp_cmd[$];
    bit   chk_rd  = 1'b0;
    bit   chk_cmd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge TDRCLK);
        #1;
    endtask

    task automatic shift_cmd(input logic we, input logic [27:0] addr, input logic [15:0] data);
        logic [44:0] c;
        c = {data, we, addr};
        cmd_shift = 1'b1;
        for (int i = 0; i < 45; i++) begin
            WSI = c[i];
            tick();
        end
        cmd_shift = 1'b0;
        WSI = 1'b0;
    endtask

    task automatic update_cmd;
        cmd_upd = 1'b1;
        tick();
        cmd_upd = 1'b0;
    endtask

    // Ack is sampled on the n-th edge after the current point.
    task automatic give_ack(input int n, input logic [15:0] rd);
        repeat (n - 1) tick();
        CsrAck = 1'b1;
        CsrRdData = rd;
        tick();
        CsrAck = 1'b0;
        CsrRdData = 16'h0;
    endtask

    task automatic expect_txn(input logic we, input logic [27:0] addr, input logic [15:0] data, input int len);
        txn_t t;
        t.we = we; t.addr = addr; t.data = data; t.len = len;
        exp_txn.push_back(t);
    endtask

    // both=1: capture and shift asserted together on the capture edge (WSI=1), capture must win.
    task automatic read_rd(input logic [15:0] v, input bit both);
        for (int i = 0; i < 16; i++) exp_rd.push_back(v[i]);
        if (both) begin
            rd_cap = 1'b1; rd_shift = 1'b1; WSI = 1'b1;
            tick();
            rd_cap = 1'b0; WSI = 1'b0;
        end else begin
            rd_cap = 1'b1;
            tick();
            rd_cap = 1'b0; rd_shift = 1'b1;
        end
        chk_rd = 1'b1;
        repeat (16) tick();
        rd_shift = 1'b0;
        chk_rd = 1'b0;
        chk("rd_bits_consumed", exp_rd.size(), 0);
    endtask

    task automatic read_cmd(input logic [44:0] v, input bit both);
        for (int i = 0; i < 45; i++) exp_cmd.push_back(v[i]);
        if (both) begin
            cmd_cap = 1'b1; cmd_shift = 1'b1; WSI = 1'b1;
            tick();
            cmd_cap = 1'b0; WSI = 1'b0;
        end else begin
            cmd_cap = 1'b1;
            tick();
            cmd_cap = 1'b0; cmd_shift = 1'b1;
        end
        chk_cmd = 1'b1;
        repeat (45) tick();
        cmd_shift = 1'b0;
        chk_cmd = 1'b0;
        chk("cmd_bits_consumed", exp_cmd.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},     CsrReq, 0);
        chk({tag, "_busy"},    CsrBusy, 0);
        chk({tag, "_we"},      CsrWe, 0);
        chk({tag, "_addr"},    CsrAddr, 0);
        chk({tag, "_wrdata"},  CsrWrData, 0);
        chk({tag, "_toerr"},   CsrTimeoutErr, 0);
        chk({tag, "_overrun"}, CsrOverrunErr, 0);
        chk({tag, "_cmdtdo"},  cmd_tdo, 0);
        chk({tag, "_rdtdo"},   rd_tdo, 0);
    endtask

    // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
    bit   in_req = 1'b0;
    int   cur_len = 0;
    txn_t cur;

    always @(negedge TDRCLK) begin
        if (chk_rd && rd_shift) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_tdo_unexpected: actual=%0b required=none", rd_tdo);
            end else begin
                chk("rd_tdo", rd_tdo, exp_rd.pop_front());
            end
        end
        if (chk_cmd && cmd_shift) begin
            if (exp_cmd.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_tdo_unexpected: actual=%0b required=none", cmd_tdo);
            end else begin
                chk("cmd_tdo", cmd_tdo, exp_cmd.pop_front());
            end
        end
        if (CsrReq === 1'b1) begin
            if (!in_req) begin
                in_req   = 1'b1;
                cur_len  = 0;
                cur.we   = CsrWe;
                cur.addr = CsrAddr;
                cur.data = CsrWrData;
                chk("busy_with_req", CsrBusy, 1);
            end
            cur_len++;
        end else if (in_req) begin
            in_req = 1'b0;
            if (exp_txn.size() == 0) begin
                checks++; errors++;
                $display("FAIL txn_unexpected: actual addr=%0h len=%0d required=none", cur.addr, cur_len);
            end else begin
                txn_t e;
                e = exp_txn.pop_front();
                chk("txn_we",   cur.we, e.we);
                chk("txn_addr", cur.addr, e.addr);
                chk("txn_data", cur.data, e.data);
                chk("txn_len",  cur_len, e.len);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        tick(); tick();
        WRST = 1'b0;
        chk_all_zero("reset");

        // 1: write, ack on the 3rd REQ cycle
        expect_txn(1'b1, 28'h00D0042, 16'hA5C3, 3);
        shift_cmd(1'b1, 28'h00D0042, 16'hA5C3);
        update_cmd();
        give_ack(3, 16'h0);
        repeat (2) tick();
        chk("t1_req_low", CsrReq, 0);
        chk("t1_no_toerr", CsrTimeoutErr, 0);
        chk("t1_no_overrun", CsrOverrunErr, 0);

        // 2: read returning 1234, shifted out LSB first
        expect_txn(1'b0, 28'h0020000, 16'h0000, 2);
        shift_cmd(1'b0, 28'h0020000, 16'h0000);
        update_cmd();
        give_ack(2, 16'h1234);
        tick();
        read_rd(16'h1234, 1'b0);

        // 3: read with no ack times out after 64 cycles
        expect_txn(1'b0, 28'h0000123, 16'h0000, 64);
        shift_cmd(1'b0, 28'h0000123, 16'h0000);
        update_cmd();
        repeat (70) tick();
        chk("t3_req_low", CsrReq, 0);
        chk("t3_toerr", CsrTimeoutErr, 1);
        read_rd(16'hDEAD, 1'b0);

        // 4: overrun - chain disturbed and re-updated 2 cycles into the first access
        expect_txn(1'b1, 28'h0ABCDEF, 16'h5A5A, 5);
        shift_cmd(1'b1, 28'h0ABCDEF, 16'h5A5A);
        update_cmd();
        cmd_shift = 1'b1; WSI = 1'b1;
        tick(); tick();
        cmd_shift = 1'b0; WSI = 1'b0;
        update_cmd();
        give_ack(2, 16'h0);
        tick();
        chk("t4_overrun", CsrOverrunErr, 1);
        chk("t4_addr_kept", CsrAddr, 28'h0ABCDEF);
        chk("t4_data_kept", CsrWrData, 16'h5A5A);
        read_cmd({16'h5A5A, 1'b1, 28'h0ABCDEF}, 1'b0);

        // 6: capture and shift together - capture wins on both chains
        read_rd(16'hDEAD, 1'b1);
        read_cmd({16'h5A5A, 1'b1, 28'h0ABCDEF}, 1'b1);

        // 5: reset after 5 REQ cycles
        expect_txn(1'b0, 28'h0000777, 16'h0000, 5);
        shift_cmd(1'b0, 28'h0000777, 16'h0000);
        update_cmd();
        repeat (4) tick();
        WRST = 1'b1;
        tick();
        WRST = 1'b0;
        chk_all_zero("t5_after_reset");
        CsrAck = 1'b1; CsrRdData = 16'hFFFF;
        tick();
        CsrAck = 1'b0; CsrRdData = 16'h0;
        tick();
        chk("t5_ack_ignored_req", CsrReq, 0);
        chk("t5_ack_ignored_busy", CsrBusy, 0);
        read_cmd(45'h0, 1'b0);
        read_rd(16'h0000, 1'b0);

        tick();
        chk("txn_queue_drained", exp_txn.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
